// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline-stage register with valid/ready handshake,
// 2-entry skid buffer, flush, legacy stall and saturating hazard counters.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = 69,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic [STAT_W-1:0] bubble_cnt_o
);

  // state is {main_valid, skid_valid}; 2'b01 cannot be reached
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_SKID  = 2'b11;

  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_ONE =
    {{(STAT_W-1){1'b0}}, 1'b1};

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [STAT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [STAT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic       accept;
  logic       take;
  logic [1:0] state;

  assign state  = {main_valid_q, skid_valid_q};
  assign accept = valid_i & ~skid_valid_q;
  assign take   = main_valid_q & ready_i & ~stall_i;

  assign ready_o      = ~skid_valid_q;
  assign valid_o      = main_valid_q;
  assign ctrl_o       = main_valid_q ? main_ctrl_q : '0;
  assign data_o       = main_data_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

  // next-state of the main/skid pair; flush overrides everything
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = ctrl_i;
            main_data_d  = data_i;
          end
        end
        ST_FULL: begin
          if (accept && take) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = ctrl_i;
            skid_data_d  = data_i;
          end else if (take) begin
            main_valid_d = 1'b0;
          end
        end
        ST_SKID: begin
          if (take) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  // saturating hazard counters; clear wins over increment
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stat_clr_i) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (main_valid_q && !take && stall_cnt_q != STAT_MAX)
        stall_cnt_d = stall_cnt_q + STAT_ONE;
      if (!main_valid_q && bubble_cnt_q != STAT_MAX)
        bubble_cnt_d = bubble_cnt_q + STAT_ONE;
    end
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register for the CPU pipeline, intended to replace the fixed-width stage latches between pipeline stages (MEM/WB and peers). It carries a control field and a data payload with a valid/ready handshake, a synchronous flush, a legacy stall input, and a 2-entry skid buffer so that `ready_o` is driven only from registers. Saturating stall and bubble counters expose per-stage hazard statistics.

## Interface
- `CTRL_W`, 2: control field width (e.g. {MemToReg, RegWrite}); cleared on flush and masked on bubbles.
- `DATA_W`, 69: payload width (e.g. RDaddr + ALUdata + DataMem packed).
- `STAT_W`, 16: width of each statistics counter.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `valid_i`  in  1  upstream entry valid.
- `ready_o`  out  1  stage can accept; equals NOT skid_valid (register-driven).
- `ctrl_i`  in  CTRL_W  upstream control field.
- `data_i`  in  DATA_W  upstream payload.
- `valid_o`  out  1  output entry valid.
- `ready_i`  in  1  downstream can accept.
- `stall_i`  in  1  legacy hold; effective downstream ready is `ready_i & ~stall_i`.
- `flush_i`  in  1  synchronous discard of all held entries.
- `ctrl_o`  out  CTRL_W  main control field when `valid_o`, else all zeros.
- `data_o`  out  DATA_W  main payload; holds last value when not valid.
- `stat_clr_i`  in  1  synchronous clear of both counters.
- `stall_cnt_o`  out  STAT_W  cycles with `valid_o=1` and no take.
- `bubble_cnt_o`  out  STAT_W  cycles with `valid_o=0`.

## Operation
- Definitions: accept = `valid_i & ready_o`; take = `valid_o & ready_i & ~stall_i`.
- Storage: main register {main_valid, main_ctrl, main_data}; skid register {skid_valid, skid_ctrl, skid_data}.
- States (encoded by {main_valid, skid_valid}):
  - EMPTY (0,0)
  - FULL (1,0)
  - SKID (1,1)
  - (0,1) is unreachable.
- Transitions with flush_i=0:
  - EMPTY: accept -> FULL, main <= input.
  - EMPTY: no accept -> EMPTY.
  - FULL: accept & take -> FULL, main <= input.
  - FULL: accept & ~take -> SKID, skid <= input.
  - FULL: ~accept & take -> EMPTY.
  - FULL: neither -> FULL, hold.
  - SKID: `ready_o=0`, so no accept is possible.
  - SKID: take -> FULL, main <= skid, skid_valid <= 0.
  - SKID: no take -> SKID, hold.
- Flush (highest priority, overrides every transition):
  - Next state EMPTY.
  - main_ctrl and skid_ctrl are cleared to 0.
  - Data registers hold their values.
  - An input accepted in the flush cycle is discarded.
  - A take in the flush cycle still completes downstream, since it is observed by the consumer in that cycle.
- `ctrl_o` is masked to 0 whenever `valid_o=0`, so bubbles never assert RegWrite or MemToReg.
- FIFO order is preserved: an entry in skid always exits after the entry in main.
- Counters:
  - Counters are unsigned and saturate at 2^STAT_W-1; they do not wrap.
  - `stat_clr_i` has priority over increment; the cycle in which clear is asserted is not counted.
  - Counters are unaffected by flush.

## Timing
- Reset values:
  - `valid_o=0`, `ready_o=1`, `ctrl_o=0`, `data_o=0`.
  - Both counters 0; state EMPTY.
- Latency: an entry accepted at edge N is visible on `valid_o`/`data_o` after edge N, i.e. 1 cycle.
- Throughput: 1 entry per cycle while the effective downstream ready stays high.
- `ready_o` falls the cycle after an accept with no take in FULL, and rises the cycle after the skid drains.
- The upstream producer may therefore issue one more entry after the downstream stalls without loss.
- `stall_i` and `ready_i` are equivalent for the handshake; either low blocks take.
- Reset asserted mid-operation:
  - All registers clear immediately, without waiting for a clock edge.
  - In-flight entries are lost.
  - `ready_o` goes to 1 asynchronously.
- Simultaneous flush and `stat_clr_i`: both take effect in the same cycle.

## Test plan
- Reset then stream: 4 back-to-back entries with data 0x1..0x4, `ctrl=2'b01`, `ready_i=1` -> `valid_o` high on cycles 1-4 carrying 0x1..0x4 in order; `ready_o` stays 1; `bubble_cnt_o=1` (reset-exit cycle only).
- Skid fill: stream 0xA, 0xB, 0xC while `stall_i=1` from the cycle 0xA appears -> 0xB captured in skid, `ready_o=0`, 0xC held upstream. `stall_i` drops -> output sequence 0xA, 0xB, 0xC with no loss or duplication; `stall_cnt_o` equals stalled cycles.
- Flush in SKID: state SKID holding 0x5/0x6, `ctrl=2'b11`, assert `flush_i` for 1 cycle -> next cycle `valid_o=0`, `ctrl_o=0`, `ready_o=1`; 0x5 and 0x6 never reappear.
- Flush with concurrent accept: EMPTY, `valid_i=1` with data 0x7 and `flush_i=1` -> 0x7 is dropped; `valid_o=0` the next cycle.
- Saturation: `STAT_W=4`, hold `ready_i=0` with a valid entry for 20 cycles -> `stall_cnt_o` stops at 15. Pulse `stat_clr_i` -> counter reads 0 the next cycle.
- Async reset mid-stream: assert `rst_i` between clock edges while in SKID -> `valid_o=0`, `ready_o=1`, counters 0 before the next edge.
